// File: rtl/shift_pkg.sv
`default_nettype none
//============================================================================
// Module      : shift_pkg
// Description : Constants and types shared between the left shifter and
//               its upstream command buffer.
//               - CMD_DATA_WIDTH  : shifter data width
//               - CMD_SHIFT_WIDTH : shift-amount width, clog2(CMD_DATA_WIDTH)
//               - cmd_t           : one shift command {bits, shift}
//               - clog2()         : ceiling log2 usable in constant contexts
// Revision    : 1.0 - initial release
//============================================================================
package shift_pkg;

    localparam int CMD_DATA_WIDTH  = 8;
    localparam int CMD_SHIFT_WIDTH = 3;

    typedef struct packed {
        logic [CMD_DATA_WIDTH-1:0]  bits;
        logic [CMD_SHIFT_WIDTH-1:0] shift;
    } cmd_t;

    // Ceiling log2. clog2(1) returns 0; callers that need at least one bit
    // must guard for that themselves.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_cmd_store.sv
`default_nettype none
//============================================================================
// Module      : shift_cmd_store
// Description : DEPTH-entry register array holding packed shift commands.
//               One synchronous write port, one combinational read port.
//               The array has no reset: occupancy is tracked by the owner,
//               so stale entries are never observed.
// Ports       : clk        - clock
//               i_wr_en    - write strobe
//               i_wr_addr  - write entry index
//               i_wr_data  - packed command to store
//               i_rd_addr  - read entry index
//               o_rd_data  - packed command at i_rd_addr (combinational)
// Revision    : 1.0 - initial release
//============================================================================
module shift_cmd_store #(
    parameter int WIDTH      = 11,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so every address value maps to a real entry.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : shift_cmd_store
`default_nettype wire

// File: rtl/shift_cmd_fifo.sv
`default_nettype none
//============================================================================
// Module      : shift_cmd_fifo
// Description : In-order command buffer directly upstream of the
//               combinational left shifter. Accepts (bits, shift) commands
//               on a valid/ready interface and presents the head command on
//               out_bits/out_shift, which wire straight into the shifter.
//               Flow control depends on registered state only, so there is
//               no combinational path from input to output or from
//               out_ready to in_ready.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               clear      - synchronous flush, priority over push/pop
//               in_valid   - producer has a command
//               in_ready   - a command can be accepted this cycle
//               in_bits    - command data word
//               in_shift   - command shift amount
//               out_valid  - head command present
//               out_ready  - consumer takes the head command this cycle
//               out_bits   - head data (0 when empty)
//               out_shift  - head shift amount (0 when empty)
//               count      - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
//============================================================================
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = CMD_DATA_WIDTH,
    parameter int SHIFT_WIDTH = CMD_SHIFT_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_bits,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_bits,
    output logic [SHIFT_WIDTH-1:0] out_shift,
    output logic [clog2(DEPTH):0]  count
);

    localparam int c_ptr_w = clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_rec_w = DATA_WIDTH + SHIFT_WIDTH;

    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [c_rec_w-1:0] w_wr_data;
    logic [c_rec_w-1:0] w_rd_data;

    //------------------------------------------------------------------------
    // Flow control: both flags come from the registered count only.
    //------------------------------------------------------------------------
    assign w_in_ready  = (r_count != c_full);
    assign w_out_valid = (r_count != '0);

    assign w_push = in_valid  & w_in_ready;
    assign w_pop  = w_out_valid & out_ready;

    //------------------------------------------------------------------------
    // Pointers and occupancy. Pointers are exactly log2(DEPTH) bits wide so
    // they wrap from DEPTH-1 to 0 by plain overflow.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Storage. A push in a clear cycle is dropped, so the write is gated too;
    // the entry would be unreachable anyway, this just keeps the array quiet.
    //------------------------------------------------------------------------
    assign w_wr_data = {in_bits, in_shift};

    shift_cmd_store #(
        .WIDTH      (c_rec_w),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (c_ptr_w)
    ) u_store (
        .clk       (clk),
        .i_wr_en   (w_push & ~clear),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    //------------------------------------------------------------------------
    // Outputs. The head is forced to zero while empty so the shifter never
    // sees stale or uninitialised array contents.
    //------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;

    assign out_bits  = w_out_valid ? w_rd_data[c_rec_w-1 -: DATA_WIDTH] : '0;
    assign out_shift = w_out_valid ? w_rd_data[SHIFT_WIDTH-1:0]         : '0;

endmodule : shift_cmd_fifo
`default_nettype wire
